// File: rtl/multi_spinner.sv
// Multi-channel spinner/rotary position accumulator.
// Digital presses accelerate; analog axes add a scaled delta per tick.
module multi_spinner #(
   parameter int CHANNELS     = 2,
   parameter int WIDTH        = 8,
   parameter int STEP_MIN     = 1,
   parameter int STEP_MAX     = 4,
   parameter int ACCEL_TICKS  = 3,
   parameter int ANALOG_SHIFT = 4,
   parameter int INIT         = 0
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [CHANNELS-1:0]       plus,
   input  logic [CHANNELS-1:0]       minus,
   input  logic [8*CHANNELS-1:0]     analog,
   input  logic [CHANNELS-1:0]       analog_en,
   input  logic [CHANNELS-1:0]       clamp,
   input  logic                      strobe,
   output logic [WIDTH*CHANNELS-1:0] spin_angle,
   output logic [CHANNELS-1:0]       moved
);

   // Sum width also covers the full analog range on narrow channels.
   localparam int SW = (WIDTH + 2 > 10) ? WIDTH + 2 : 10;
   localparam int HW = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

   localparam logic [1:0] DIR_NONE = 2'd0;
   localparam logic [1:0] DIR_UP   = 2'd1;
   localparam logic [1:0] DIR_DN   = 2'd2;

   localparam logic [WIDTH-1:0] SPD_MIN = WIDTH'(STEP_MIN);
   localparam logic [WIDTH-1:0] SPD_MAX = WIDTH'(STEP_MAX);
   localparam logic signed [SW-1:0] POS_MAX = SW'((1 << WIDTH) - 1);

   logic strobe_s1;
   logic strobe_s2;
   logic strobe_d;
   logic tick;

   // Synchronise strobe and delay it once for rising-edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         strobe_s1 <= 1'b0;
         strobe_s2 <= 1'b0;
         strobe_d  <= 1'b0;
      end else begin
         strobe_s1 <= strobe;
         strobe_s2 <= strobe_s1;
         strobe_d  <= strobe_s2;
      end
   end

   assign tick = strobe_s2 & ~strobe_d;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic signed [7:0]    an;
      logic signed [SW-1:0] an_ext;
      logic signed [SW-1:0] an_shift;
      logic signed [SW-1:0] spd_ext;
      logic signed [SW-1:0] delta;
      logic signed [SW-1:0] sum;
      logic [WIDTH-1:0]     pos_q;
      logic [WIDTH-1:0]     pos_n;
      logic [WIDTH-1:0]     speed_q;
      logic [WIDTH-1:0]     speed_n;
      logic [WIDTH-1:0]     base_speed;
      logic [HW-1:0]        hold_q;
      logic [HW-1:0]        hold_n;
      logic [HW-1:0]        base_hold;
      logic [1:0]           dir_q;
      logic [1:0]           dir_n;
      logic                 up;
      logic                 dn;
      logic                 moved_q;
      int                   hold_inc;

      assign an     = analog[8*g +: 8];
      assign an_ext = {{(SW-8){an[7]}}, an};
      assign up     = plus[g] & ~minus[g];
      assign dn     = minus[g] & ~plus[g];

      // Next speed/hold/direction and the clamped or wrapped position.
      always_comb begin
         an_shift   = an_ext >>> ANALOG_SHIFT;
         delta      = '0;
         speed_n    = SPD_MIN;
         hold_n     = '0;
         dir_n      = DIR_NONE;
         base_speed = SPD_MIN;
         base_hold  = '0;
         hold_inc   = 0;
         spd_ext    = '0;
         if (analog_en[g]) begin
            if (an != 0 && an_shift == 0)
               delta = an[7] ? {SW{1'b1}} : SW'(1);
            else
               delta = an_shift;
         end else if (up | dn) begin
            dir_n = up ? DIR_UP : DIR_DN;
            if (dir_n == dir_q) begin
               base_speed = speed_q;
               base_hold  = hold_q;
            end
            spd_ext  = {{(SW-WIDTH){1'b0}}, base_speed};
            delta    = up ? spd_ext : -spd_ext;
            hold_inc = int'(base_hold) + 1;
            if (hold_inc >= ACCEL_TICKS) begin
               hold_n  = '0;
               speed_n = (base_speed >= SPD_MAX) ? SPD_MAX
                                                 : base_speed + 1'b1;
            end else begin
               hold_n  = HW'(hold_inc);
               speed_n = base_speed;
            end
         end
         sum = $signed({{(SW-WIDTH){1'b0}}, pos_q}) + delta;
         if (clamp[g] && sum < 0)
            pos_n = '0;
         else if (clamp[g] && sum > POS_MAX)
            pos_n = {WIDTH{1'b1}};
         else
            pos_n = sum[WIDTH-1:0];
      end

      // Commit channel state on the tick and flag a position change.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            pos_q   <= WIDTH'(INIT);
            speed_q <= SPD_MIN;
            hold_q  <= '0;
            dir_q   <= DIR_NONE;
            moved_q <= 1'b0;
         end else if (tick) begin
            pos_q   <= pos_n;
            speed_q <= speed_n;
            hold_q  <= hold_n;
            dir_q   <= dir_n;
            moved_q <= (pos_n != pos_q);
         end else begin
            moved_q <= 1'b0;
         end
      end

      assign spin_angle[WIDTH*g +: WIDTH] = pos_q;
      assign moved[g]                     = moved_q;
   end

endmodule

// File: tb/tb_multi_spinner.sv
// Randomised scoreboard bench for multi_spinner (default parameters).
// A press-count model predicts every position change.
module tb_multi_spinner;

   localparam int CH = 2;

   typedef struct {
      logic [15:0] ang;
      logic [1:0]  mv;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  plus = '0;
   logic [1:0]  minus = '0;
   logic [15:0] analog = '0;
   logic [1:0]  analog_en = '0;
   logic [1:0]  clamp = '0;
   logic        strobe = 1'b0;
   logic [15:0] spin_angle;
   logic [1:0]  moved;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   m_pos[CH];
   int   m_run[CH];
   int   m_dir[CH];

   multi_spinner dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .plus       (plus),
      .minus      (minus),
      .analog     (analog),
      .analog_en  (analog_en),
      .clamp      (clamp),
      .strobe     (strobe),
      .spin_angle (spin_angle),
      .moved      (moved)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: every moved pulse must match the next predicted update.
   always @(negedge clk) begin
      if (reset_n && moved != 2'b00) begin
         if (sb.size() == 0) begin
            chk("unexpected_moved", int'(moved), 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("angle", int'(spin_angle), int'(e.ang));
            chk("moved", int'(moved), int'(e.mv));
         end
      end
   end

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_pos[c] = 0;
         m_run[c] = 0;
         m_dir[c] = 0;
      end
   endtask

   // Step = STEP_MIN + (run-1)/ACCEL_TICKS, capped at STEP_MAX.
   task automatic model_tick();
      logic [1:0] mv;
      exp_t e;
      mv = '0;
      for (int c = 0; c < CH; c++) begin
         int d, a, np, dr, st;
         d = 0;
         a = $signed(analog[8*c +: 8]);
         if (analog_en[c]) begin
            m_run[c] = 0;
            m_dir[c] = 0;
            d = (a >= 0) ? a / 16 : -((-a + 15) / 16);
            if (a > 0 && d == 0) d = 1;
         end else if (plus[c] != minus[c]) begin
            dr = plus[c] ? 1 : -1;
            m_run[c] = (dr == m_dir[c]) ? m_run[c] + 1 : 1;
            m_dir[c] = dr;
            st = 1 + (m_run[c] - 1) / 3;
            if (st > 4) st = 4;
            d = dr * st;
         end else begin
            m_run[c] = 0;
            m_dir[c] = 0;
         end
         np = m_pos[c] + d;
         if (clamp[c]) begin
            if (np < 0) np = 0;
            if (np > 255) np = 255;
         end else begin
            np = ((np % 256) + 256) % 256;
         end
         if (np != m_pos[c]) mv[c] = 1'b1;
         m_pos[c] = np;
      end
      if (mv != 2'b00) begin
         e.ang = {m_pos[1][7:0], m_pos[0][7:0]};
         e.mv  = mv;
         sb.push_back(e);
      end
   endtask

   task automatic do_tick(input logic [1:0] p, input logic [1:0] m,
                          input logic [15:0] an, input logic [1:0] en,
                          input logic [1:0] cl, input int hi);
      @(negedge clk);
      plus = p;
      minus = m;
      analog = an;
      analog_en = en;
      clamp = cl;
      model_tick();
      strobe = 1'b1;
      repeat (hi) @(negedge clk);
      strobe = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic chk_pos(input string nm);
      chk(nm, int'(spin_angle), m_pos[1] * 256 + m_pos[0]);
   endtask

   initial begin
      model_reset();
      #1;
      chk("reset_angle", int'(spin_angle), 0);
      chk("reset_moved", int'(moved), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 10; i++)
         do_tick(2'b01, 2'b00, 16'h0, 2'b00, 2'b00, 6);
      chk("accel_22", int'(spin_angle), 22);

      do_tick(2'b00, 2'b10, 16'h0, 2'b00, 2'b00, 6);
      chk("wrap_255", int'(spin_angle[15:8]), 255);
      do_tick(2'b10, 2'b00, 16'h0, 2'b00, 2'b00, 6);
      do_tick(2'b00, 2'b10, 16'h0, 2'b00, 2'b10, 6);
      chk("clamp_0", int'(spin_angle[15:8]), 0);

      do_tick(2'b00, 2'b00, 16'h0000, 2'b00, 2'b00, 6);
      for (int i = 0; i < 3; i++)
         do_tick(2'b00, 2'b00, 16'h0050, 2'b01, 2'b00, 6);
      do_tick(2'b00, 2'b00, 16'h0003, 2'b01, 2'b00, 6);
      do_tick(2'b00, 2'b00, 16'h00FD, 2'b01, 2'b00, 6);
      do_tick(2'b00, 2'b00, 16'h0000, 2'b01, 2'b00, 6);
      chk_pos("analog_seq");

      for (int i = 0; i < 4; i++)
         do_tick(2'b01, 2'b00, 16'h0, 2'b00, 2'b00, 6);
      do_tick(2'b00, 2'b01, 16'h0, 2'b00, 2'b00, 6);
      do_tick(2'b01, 2'b01, 16'h0, 2'b00, 2'b00, 6);
      chk_pos("dir_change");

      do_tick(2'b11, 2'b00, 16'h0, 2'b00, 2'b00, 100);
      chk_pos("held_strobe");

      // Short press between ticks must be ignored.
      @(negedge clk);
      plus = 2'b11;
      repeat (3) @(negedge clk);
      plus = 2'b00;
      repeat (6) @(negedge clk);
      chk_pos("glitch_press");

      // Reset with a tick pending in the synchroniser.
      plus = 2'b01;
      strobe = 1'b1;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_angle", int'(spin_angle), 0);
      chk("async_reset_moved", int'(moved), 0);
      strobe = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("pending_tick_dropped", int'(spin_angle), 0);
      do_tick(2'b01, 2'b00, 16'h0, 2'b00, 2'b00, 6);
      chk("restart_step1", int'(spin_angle), 1);

      for (int i = 0; i < 200; i++) begin
         logic [1:0] p, m, en, cl;
         logic [15:0] an;
         p  = 2'($urandom);
         m  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         en = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00;
         cl = 2'($urandom);
         an = 16'($urandom);
         do_tick(p, m, an, en, cl, $urandom_range(1, 8));
      end
      chk_pos("random_final");
      chk("queue_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_spinner.md
MULTI_SPINNER -- requirements
Module: multi_spinner

Interface
REQ-001 Parameter CHANNELS, default 2, number of independent spinner channels (1..8).
REQ-002 Parameter WIDTH, default 8, bits per channel position (4..16).
REQ-003 Parameter STEP_MIN, default 1, step magnitude on first tick of a press.
REQ-004 Parameter STEP_MAX, default 4, saturating step magnitude; STEP_MIN <= STEP_MAX < 2^(WIDTH-1).
REQ-005 Parameter ACCEL_TICKS, default 3, consecutive same-direction ticks per step increment (>=1).
REQ-006 Parameter ANALOG_SHIFT, default 4, arithmetic right shift applied to analog input (0..7).
REQ-007 Parameter INIT, default 0, reset value of every channel position.
REQ-008 clk  in  1  system clock; all state on its rising edge.
REQ-009 reset_n  in  1  asynchronous, active-low reset.
REQ-010 plus  in  CHANNELS  per-channel increment request (level).
REQ-011 minus  in  CHANNELS  per-channel decrement request (level).
REQ-012 analog  in  8*CHANNELS  per-channel signed two's-complement analog axis, channel i at [8i+7:8i].
REQ-013 analog_en  in  CHANNELS  per-channel select: 1 = analog source, 0 = plus/minus source.
REQ-014 clamp  in  CHANNELS  per-channel mode: 0 = wrap modulo 2^WIDTH, 1 = saturate at 0 and 2^WIDTH-1.
REQ-015 strobe  in  1  update pacing (vertical sync), asynchronous level; rising edge = tick.
REQ-016 spin_angle  out  WIDTH*CHANNELS  registered position, channel i at [WIDTH*i+WIDTH-1:WIDTH*i].
REQ-017 moved  out  CHANNELS  one-cycle pulse when the channel position changed.

Function
REQ-018 strobe SHALL pass a 2-flop synchronizer plus one delay flop; tick = synced high AND delayed low, one clk wide.
REQ-019 A strobe held high SHALL produce exactly one tick; no tick on falling edge.
REQ-020 All channels SHALL update only on the tick cycle; spin_angle and moved become visible the following clk edge.
REQ-021 Per channel, digital state: speed (STEP_MIN..STEP_MAX), hold counter (0..ACCEL_TICKS-1), last direction (NONE/UP/DOWN).
REQ-022 Digital, plus only: delta = +speed; minus only: delta = -speed; neither or both: delta = 0.
REQ-023 On a tick with delta != 0 in the same direction as last: after use, hold+1; on reaching ACCEL_TICKS, hold=0 and speed=min(speed+1,STEP_MAX).
REQ-024 Direction change, idle (neither/both) on a tick, or analog_en=1 SHALL set speed=STEP_MIN, hold=0, then apply REQ-023 counting from that tick if moving.
REQ-025 Analog: delta = analog >>> ANALOG_SHIFT (sign-preserving); if analog != 0 and result 0, delta = +1 or -1 by sign of analog; analog = 0 gives delta 0.
REQ-026 Sum SHALL be computed in WIDTH+2 signed bits; wrap mode keeps low WIDTH bits; clamp mode limits to [0, 2^WIDTH-1].
REQ-027 moved[i] SHALL be 1 for exactly the cycle spin_angle[i] takes a new differing value; clamped-at-limit or zero delta gives no pulse.
REQ-028 Changes of clamp or analog_en between ticks SHALL take effect on the next tick; position is not altered by the change itself.
REQ-029 Channels SHALL be fully independent; simultaneous activity on all channels updates all on the same tick.
REQ-030 Input levels SHALL be sampled only on the tick cycle; presses shorter than a tick period between ticks are ignored.

Reset
REQ-031 reset_n low SHALL immediately set every spin_angle channel to INIT[WIDTH-1:0], moved to 0, speed to STEP_MIN, hold to 0, direction NONE, synchronizer flops to 0.
REQ-032 Assertion mid-operation SHALL discard any pending tick; first tick after release requires a fresh strobe rising edge observed after release.

Verification (defaults)
REQ-033 plus[0]=1 for 10 ticks, wrap -> steps 1,1,1,2,2,2,3,3,3,4; spin_angle[0]=22, moved[0] pulsed 10 times, channel 1 stays 0.
REQ-034 From 0, minus[1]=1 one tick, wrap -> 255; same with clamp[1]=1 -> stays 0, no moved pulse.
REQ-035 analog_en[0]=1: analog=0x50 three ticks -> 15; then 0x03 one tick -> 16; then 0xFD one tick -> 15; then 0x00 -> no change.
REQ-036 plus[0] 4 ticks (angle 5, speed 2), then minus[0] 1 tick -> 4 (speed reset to 1); plus and minus both high -> no change.
REQ-037 strobe held high 100 clks -> single update; reset_n pulsed low mid-press -> angle 0 at once, next press restarts at step 1.
